// File: rtl/program_sequencer_dbg_if.sv
// Bundle of the ROM, decoder and debug signals around the program sequencer.
// The sequencer uses the master view; its environment uses the slave view.
interface program_sequencer_dbg_if #(
   parameter int CNT_W = 16
);
   logic             jmp;
   logic             jmp_nz;
   logic [3:0]       ir_nibble;
   logic             dont_jmp;
   logic [7:0]       pm_data;
   logic             halt_req;
   logic             run_req;
   logic             step_req;
   logic             bp_en;
   logic [7:0]       bp_addr;
   logic             cnt_clr;
   logic [7:0]       pm_addr;
   logic [7:0]       pc;
   logic [7:0]       next_instr;
   logic             halted;
   logic [CNT_W-1:0] retired_cnt;
   logic [7:0]       from_PS;

   modport master (
      input  jmp, jmp_nz, ir_nibble, dont_jmp, pm_data,
      input  halt_req, run_req, step_req, bp_en, bp_addr, cnt_clr,
      output pm_addr, pc, next_instr, halted, retired_cnt, from_PS
   );

   modport slave (
      output jmp, jmp_nz, ir_nibble, dont_jmp, pm_data,
      output halt_req, run_req, step_req, bp_en, bp_addr, cnt_clr,
      input  pm_addr, pc, next_instr, halted, retired_cnt, from_PS
   );
endinterface

// File: rtl/program_sequencer_dbg.sv
// Program counter / fetch front end with halt, single-step, breakpoint and a
// retired-instruction counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | fetch advances every cycle, ROM data issued to the decoder
// ST_HALT | pc re-fetched without advancing, NOP issued
// ST_STEP | one instruction issued, then back to ST_HALT
module program_sequencer_dbg #(
   parameter logic [7:0] NOP_INSTR    = 8'h80,
   parameter int         RESET_HALTED = 0,
   parameter int         CNT_W        = 16
) (
   input logic                     clk,
   input logic                     sync_reset,
   program_sequencer_dbg_if.master bus
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   localparam state_e RESET_STATE = (RESET_HALTED != 0) ? ST_HALT : ST_RUN;

   state_e           state_q, state_d;
   logic [7:0]       pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       take_jump;
   logic       issue;
   logic       bp_hit;
   logic [7:0] jmp_target;
   logic [7:0] pm_addr_c;

   always_comb begin
      take_jump  = bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);
      jmp_target = {bus.ir_nibble, 4'h0};

      // The instruction already in ir always completes, so jumps win over HALT.
      if (sync_reset)
         pm_addr_c = 8'h00;
      else if (take_jump)
         pm_addr_c = jmp_target;
      else if (state_q == ST_HALT)
         pm_addr_c = pc_q;
      else
         pm_addr_c = pc_q + 8'd1;

      pc_d   = pm_addr_c;
      issue  = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !sync_reset;
      bp_hit = bus.bp_en & (pm_addr_c == bus.bp_addr) & ~take_jump;

      state_d = state_q;
      case (state_q)
         ST_RUN:  if (bus.halt_req || bp_hit) state_d = ST_HALT;
         ST_HALT: begin
            if (bus.run_req)
               state_d = ST_RUN;
            else if (bus.step_req)
               state_d = ST_STEP;
         end
         ST_STEP: state_d = bus.run_req ? ST_RUN : ST_HALT;
         default: state_d = RESET_STATE;
      endcase

      cnt_d = cnt_q;
      if (bus.cnt_clr)
         cnt_d = '0;
      else if (issue)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q <= RESET_STATE;
         pc_q    <= 8'h00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pm_addr     = pm_addr_c;
   assign bus.pc          = pc_q;
   assign bus.from_PS     = pc_q;
   assign bus.halted      = (state_q == ST_HALT);
   assign bus.next_instr  = issue ? bus.pm_data : NOP_INSTR;
   assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_program_sequencer_dbg.sv
// Vector/scoreboard bench for program_sequencer_dbg against a ROM holding n+8'h10.
module tb_program_sequencer_dbg;

   logic clk;
   logic sync_reset;
   logic [7:0] rom_q;

   program_sequencer_dbg_if #(.CNT_W(16)) bus ();

   program_sequencer_dbg #(
      .NOP_INSTR    (8'h80),
      .RESET_HALTED (0),
      .CNT_W        (16)
   ) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data is the word at the address presented last cycle.
   always @(posedge clk) rom_q <= bus.pm_addr + 8'h10;
   assign bus.pm_data = rom_q;

   typedef struct {
      string       name;
      logic        rst, jmp, jnz;
      logic [3:0]  nib;
      logic        dont, halt, run, step, bpen;
      logic [7:0]  bpa;
      logic        clr;
      logic [7:0]  e_pm, e_pc, e_nx;
      logic        e_h;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(string nm, logic rst, logic jmp, logic jnz, logic [3:0] nib,
                               logic dont, logic halt, logic run, logic step, logic bpen,
                               logic [7:0] bpa, logic clr, logic [7:0] e_pm, logic [7:0] e_pc,
                               logic [7:0] e_nx, logic e_h, logic [15:0] e_cnt);
      vec_t v;
      v.name = nm; v.rst = rst; v.jmp = jmp; v.jnz = jnz; v.nib = nib;
      v.dont = dont; v.halt = halt; v.run = run; v.step = step; v.bpen = bpen;
      v.bpa = bpa; v.clr = clr; v.e_pm = e_pm; v.e_pc = e_pc; v.e_nx = e_nx;
      v.e_h = e_h; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [15:0] act,
                      input logic [15:0] expv);
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s %s: got %h expected %h", nm, fld, act, expv);
      end
   endtask

   task automatic drive_idle();
      bus.jmp = 0; bus.jmp_nz = 0; bus.ir_nibble = 4'h0; bus.dont_jmp = 0;
      bus.halt_req = 0; bus.run_req = 0; bus.step_req = 0;
      bus.bp_en = 0; bus.bp_addr = 8'h00; bus.cnt_clr = 0;
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic apply(input vec_t v);
      vec_t e;
      sync_reset = v.rst; bus.jmp = v.jmp; bus.jmp_nz = v.jnz; bus.ir_nibble = v.nib;
      bus.dont_jmp = v.dont; bus.halt_req = v.halt; bus.run_req = v.run;
      bus.step_req = v.step; bus.bp_en = v.bpen; bus.bp_addr = v.bpa; bus.cnt_clr = v.clr;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      chk(e.name, "pm_addr", 16'(bus.pm_addr), 16'(e.e_pm));
      chk(e.name, "pc", 16'(bus.pc), 16'(e.e_pc));
      chk(e.name, "from_PS", 16'(bus.from_PS), 16'(e.e_pc));
      chk(e.name, "next_instr", 16'(bus.next_instr), 16'(e.e_nx));
      chk(e.name, "halted", 16'(bus.halted), 16'(e.e_h));
      chk(e.name, "retired_cnt", bus.retired_cnt, e.e_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      sync_reset = 1;
      repeat (2) @(posedge clk);
      #1;
      sync_reset = 0;
   endtask

   initial begin
      drive_idle();
      sync_reset = 1;
      @(posedge clk);
      #1;
      do_reset();

      //           name        rst jmp jnz nib   dnt hlt run stp bpe bpa    clr  pm     pc     nx     h  cnt
      tbl.push_back(mk("rst",       1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h80, 0, 16'd0));
      tbl.push_back(mk("run1",      0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'd0));
      tbl.push_back(mk("run2",      0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h02, 8'h01, 8'h11, 0, 16'd1));
      tbl.push_back(mk("run3",      0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h03, 8'h02, 8'h12, 0, 16'd2));
      tbl.push_back(mk("run4",      0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h04, 8'h03, 8'h13, 0, 16'd3));
      tbl.push_back(mk("jmpA",      0, 1, 0, 4'hA, 0, 0, 0, 0, 0, 8'h00, 0, 8'hA0, 8'h04, 8'h14, 0, 16'd4));
      tbl.push_back(mk("jnz_dont",  0, 0, 1, 4'h3, 1, 0, 0, 0, 0, 8'h00, 0, 8'hA1, 8'hA0, 8'hB0, 0, 16'd5));
      tbl.push_back(mk("jnz_take",  0, 0, 1, 4'h3, 0, 0, 0, 0, 0, 8'h00, 0, 8'h30, 8'hA1, 8'hB1, 0, 16'd6));
      tbl.push_back(mk("run30",     0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h31, 8'h30, 8'h40, 0, 16'd7));
      tbl.push_back(mk("halt_jmp",  0, 1, 0, 4'h3, 0, 1, 0, 0, 0, 8'h00, 0, 8'h30, 8'h31, 8'h41, 0, 16'd8));
      tbl.push_back(mk("halt_held", 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h30, 8'h30, 8'h80, 1, 16'd9));
      tbl.push_back(mk("run_req",   0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 8'h00, 0, 8'h30, 8'h30, 8'h80, 1, 16'd9));
      tbl.push_back(mk("resume",    0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h31, 8'h30, 8'h40, 0, 16'd9));
      tbl.push_back(mk("halt2",     0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h32, 8'h31, 8'h41, 0, 16'd10));
      tbl.push_back(mk("jmp_halted",0, 1, 0, 4'h6, 0, 0, 0, 0, 0, 8'h00, 0, 8'h60, 8'h32, 8'h80, 1, 16'd11));
      tbl.push_back(mk("halted60",  0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h60, 8'h60, 8'h80, 1, 16'd11));
      tbl.push_back(mk("run_step",  0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 8'h00, 0, 8'h60, 8'h60, 8'h80, 1, 16'd11));
      tbl.push_back(mk("clr_issue", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h61, 8'h60, 8'h70, 0, 16'd11));
      tbl.push_back(mk("after_clr", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h62, 8'h61, 8'h71, 0, 16'd0));
      tbl.push_back(mk("cnt1",      0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h63, 8'h62, 8'h72, 0, 16'd1));
      foreach (tbl[i]) apply(tbl[i]);

      // Breakpoint at 5, two single steps, then a breakpoint on a jump target.
      do_reset();
      apply(mk("bp_run1",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h01, 8'h00, 8'h10, 0, 16'd0));
      apply(mk("bp_run2",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h02, 8'h01, 8'h11, 0, 16'd1));
      apply(mk("bp_run3",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h03, 8'h02, 8'h12, 0, 16'd2));
      apply(mk("bp_run4",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h04, 8'h03, 8'h13, 0, 16'd3));
      apply(mk("bp_hit",   0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h05, 8'h04, 8'h14, 0, 16'd4));
      apply(mk("bp_hold1", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h05, 8'h05, 8'h80, 1, 16'd5));
      apply(mk("bp_hold2", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h05, 8'h05, 8'h80, 1, 16'd5));
      apply(mk("step1",    0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 8'h05, 0, 8'h05, 8'h05, 8'h80, 1, 16'd5));
      apply(mk("step1_x",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h06, 8'h05, 8'h15, 0, 16'd5));
      for (int k = 0; k < 3; k++)
         apply(mk("step_idle", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h06, 8'h06, 8'h80, 1, 16'd6));
      apply(mk("step2",    0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 8'h05, 0, 8'h06, 8'h06, 8'h80, 1, 16'd6));
      apply(mk("step2_x",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h07, 8'h06, 8'h16, 0, 16'd6));
      apply(mk("step2_h",  0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h05, 0, 8'h07, 8'h07, 8'h80, 1, 16'd7));
      apply(mk("bp_resume",0, 0, 0, 4'h0, 0, 0, 1, 0, 1, 8'h05, 0, 8'h07, 8'h07, 8'h80, 1, 16'd7));
      apply(mk("bp_jtgt",  0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h07, 8'h17, 0, 16'd7));
      apply(mk("bp_jtgt_x",0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'd8));

      // pc wrap 8'hFF -> 8'h00.
      do_reset();
      apply(mk("jmpF0", 0, 1, 0, 4'hF, 0, 0, 0, 0, 0, 8'h00, 0, 8'hF0, 8'h00, 8'h10, 0, 16'd0));
      for (int k = 0; k < 16; k++)
         apply(mk("wrap", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0,
                  8'(8'hF1 + k), 8'(8'hF0 + k), 8'(k), 0, 16'(1 + k)));
      apply(mk("wrapped", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'd17));

      // Counter wrap after 2^16-1 issued instructions.
      do_reset();
      repeat (65535) @(posedge clk);
      #1;
      apply(mk("cnt_max",  0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h0F, 0, 16'hFFFF));
      apply(mk("cnt_wrap", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'h0000));

      // Reset in the middle of STEP and of HALT.
      do_reset();
      apply(mk("e_halt",   0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'd0));
      apply(mk("e_step",   0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 8'h00, 0, 8'h01, 8'h01, 8'h80, 1, 16'd1));
      apply(mk("rst_step", 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h80, 0, 16'd1));
      apply(mk("post_rs",  0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'd0));
      apply(mk("e_halt2",  0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h02, 8'h01, 8'h11, 0, 16'd1));
      apply(mk("rst_halt", 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 8'h80, 1, 16'd2));
      apply(mk("post_rh",  0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 8'h00, 8'h10, 0, 16'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
